// File: rtl/meduram_pkg.sv
// meduram_pkg: response codes and requester FSM states shared by the RAM schedulers
package meduram_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic {IDLE, CPL} wr_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-wide round-robin one-hot grant; pointer moves past the winner after each grant
//   aclk/srst: clock and synchronous active-high reset
//   req: request vector, gnt/gnt_idx: one-hot grant and its index, rr: current highest-priority index
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 aclk,
    input  logic                 srst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic [$clog2(N)-1:0] rr
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] rr_q, rr_d;
    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v >= N ? v - N : v);
    endfunction
    // reverse scan so the requester nearest the pointer is the last to overwrite
    always_comb begin
        gnt_idx = rr_q;
        for (int k = N - 1; k >= 0; k--)
            if (req[wrap(int'(rr_q) + k)]) gnt_idx = wrap(int'(rr_q) + k);
        gnt  = (|req) ? N'(1) << gnt_idx : '0;
        rr_d = (|req) ? wrap(int'(gnt_idx) + 1) : rr_q;
    end
    always_ff @(posedge aclk)
        rr_q <= srst ? '0 : rr_d;
    assign rr = rr_q;
endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: round-robin scheduler of NB_WR write commands onto one RAM write port
//   req_*: per-requester valid/ready commands (packed addr/data/strb)
//   cpl_*: per-requester completion handshake with 2-bit response
//   ram_*: registered RAM write port, one-cycle pulse after each grant
module ram_write_arbiter
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int NB_WR           = 2,
    parameter int WRITE_COLLISION = 1
) (
    input  logic                        aclk,
    input  logic                        srst,
    input  logic [NB_WR-1:0]            req_valid,
    output logic [NB_WR-1:0]            req_ready,
    input  logic [NB_WR*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_WR*DATA_WIDTH-1:0] req_data,
    input  logic [NB_WR*DATA_WIDTH/8-1:0] req_strb,
    output logic [NB_WR-1:0]            cpl_valid,
    input  logic [NB_WR-1:0]            cpl_ready,
    output logic [NB_WR*2-1:0]          cpl_resp,
    output logic                        ram_wren,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    output logic [DATA_WIDTH/8-1:0]     ram_wstrb
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NB_WR);
    wr_state_e                state_q [NB_WR];
    wr_state_e                state_d [NB_WR];
    logic [NB_WR*2-1:0]       resp_q, resp_d;
    logic                     ram_wren_q, ram_wren_d;
    logic [ADDR_WIDTH-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
    logic [SW-1:0]            ram_wstrb_q, ram_wstrb_d;
    logic [NB_WR-1:0]         elig, arb_gnt, gnt;
    logic [IW-1:0]            win, rr;
    logic [ADDR_WIDTH-1:0]    win_addr;
    int                       j;
    // srst masks eligibility so no command is accepted while in reset
    always_comb begin
        elig = '0;
        for (int i = 0; i < NB_WR; i++)
            elig[i] = !srst && req_valid[i] && state_q[i] == IDLE;
    end
    rr_arbiter #(.N(NB_WR)) u_arb (
        .aclk    (aclk),
        .srst    (srst),
        .req     (elig),
        .gnt     (arb_gnt),
        .gnt_idx (win),
        .rr      (rr)
    );
    always_comb begin
        win_addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        gnt = arb_gnt;
        for (int i = 0; i < NB_WR; i++)
            if (WRITE_COLLISION != 0 && |arb_gnt && elig[i] && req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == win_addr)
                gnt[i] = 1'b1;
        // lanes are filled farthest-from-pointer first so the nearest merged requester wins each byte
        ram_wdata_d = '0;
        ram_wstrb_d = '0;
        j = 0;
        for (int k = NB_WR - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            j = j >= NB_WR ? j - NB_WR : j;
            for (int b = 0; b < SW; b++)
                if (gnt[j] && req_strb[j*SW + b]) begin
                    ram_wdata_d[b*8 +: 8] = req_data[j*DATA_WIDTH + b*8 +: 8];
                    ram_wstrb_d[b] = 1'b1;
                end
        end
        ram_wren_d = |gnt;
        ram_addr_d = ram_wren_d ? win_addr : '0;
        resp_d = resp_q;
        for (int i = 0; i < NB_WR; i++) begin
            state_d[i] = gnt[i] ? CPL : (state_q[i] == CPL && cpl_ready[i]) ? IDLE : state_q[i];
            resp_d[i*2 +: 2] = gnt[i] ? RESP_OKAY : resp_q[i*2 +: 2];
        end
    end
    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int i = 0; i < NB_WR; i++) state_q[i] <= IDLE;
            resp_q      <= '0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wstrb_q <= '0;
        end else begin
            for (int i = 0; i < NB_WR; i++) state_q[i] <= state_d[i];
            resp_q      <= resp_d;
            ram_wren_q  <= ram_wren_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wstrb_q <= ram_wstrb_d;
        end
    end
    always_comb begin
        cpl_valid = '0;
        for (int i = 0; i < NB_WR; i++) cpl_valid[i] = state_q[i] == CPL;
    end
    assign req_ready = gnt;
    assign cpl_resp  = resp_q;
    assign ram_wren  = ram_wren_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wstrb = ram_wstrb_q;
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter: scoreboard bench for merging (u_merge) and serializing (u_serial) instances
module tb_ram_write_arbiter;
    logic       aclk = 1'b0;
    logic       srst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] cpl_ready = '0;
    logic [5:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic [1:0] req_strb = '0;
    logic [1:0] rdy [2];
    logic [1:0] cv [2];
    logic [3:0] rsp [2];
    logic       wren [2];
    logic [2:0] ra [2];
    logic [7:0] rd [2];
    logic       rs [2];
    typedef struct {
        int         d;
        int         cyc;
        logic [2:0] a;
        logic [7:0] dat;
        logic       s;
    } wr_t;
    wr_t q[$];
    int pend [2][2];
    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    ram_write_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NB_WR(2), .WRITE_COLLISION(1)) u_merge (
        .aclk(aclk), .srst(srst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb), .cpl_valid(cv[0]), .cpl_ready(cpl_ready),
        .cpl_resp(rsp[0]), .ram_wren(wren[0]), .ram_addr(ra[0]), .ram_wdata(rd[0]), .ram_wstrb(rs[0])
    );
    ram_write_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NB_WR(2), .WRITE_COLLISION(0)) u_serial (
        .aclk(aclk), .srst(srst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb), .cpl_valid(cv[1]), .cpl_ready(cpl_ready),
        .cpl_resp(rsp[1]), .ram_wren(wren[1]), .ram_addr(ra[1]), .ram_wdata(rd[1]), .ram_wstrb(rs[1])
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic mid();
        @(negedge aclk);
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push(input int d, input logic [2:0] a, input logic [7:0] dat, input logic s, input int r, input bit cpl);
        wr_t e;
        e.d = d; e.cyc = cyc + 1; e.a = a; e.dat = dat; e.s = s;
        q.push_back(e);
        if (cpl) pend[d][r]++;
    endtask
    task automatic push2(input logic [2:0] a, input logic [7:0] dat, input logic s, input int r, input bit cpl);
        push(0, a, dat, s, r, cpl);
        push(1, a, dat, s, r, cpl);
    endtask
    task automatic chk_rdy(input string tag, input logic [1:0] e0, input logic [1:0] e1);
        chk($sformatf("%s req_ready merge", tag), rdy[0], e0);
        chk($sformatf("%s req_ready serial", tag), rdy[1], e1);
    endtask
    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d req_ready", tag, d), rdy[d], 0);
            chk($sformatf("%s dut%0d cpl_valid", tag, d), cv[d], 0);
            chk($sformatf("%s dut%0d cpl_resp", tag, d), rsp[d], 0);
            chk($sformatf("%s dut%0d ram_wren", tag, d), wren[d], 0);
            chk($sformatf("%s dut%0d ram_addr", tag, d), ra[d], 0);
            chk($sformatf("%s dut%0d ram_wdata", tag, d), rd[d], 0);
            chk($sformatf("%s dut%0d ram_wstrb", tag, d), rs[d], 0);
        end
    endtask

    // monitor: every RAM pulse and completion handshake is matched against the scoreboard
    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            int f;
            f = -1;
            for (int i = 0; i < q.size(); i++) if (f < 0 && q[i].d == d) f = i;
            if (wren[d]) begin
                vecs++;
                if (f < 0) begin
                    errs++;
                    $display("FAIL dut%0d ram write: got addr=%0h data=%0h strb=%0b at cycle %0d, expected none", d, ra[d], rd[d], rs[d], cyc);
                end else begin
                    if (ra[d] !== q[f].a || rs[d] !== q[f].s || (q[f].s && rd[d] !== q[f].dat) || q[f].cyc != cyc) begin
                        errs++;
                        $display("FAIL dut%0d ram write: got addr=%0h data=%0h strb=%0b cycle %0d, expected addr=%0h data=%0h strb=%0b cycle %0d",
                                 d, ra[d], rd[d], rs[d], cyc, q[f].a, q[f].dat, q[f].s, q[f].cyc);
                    end
                    q.delete(f);
                end
            end else if (f >= 0 && q[f].cyc <= cyc) begin
                vecs++;
                errs++;
                $display("FAIL dut%0d ram write missing: got none at cycle %0d, expected addr=%0h data=%0h", d, cyc, q[f].a, q[f].dat);
                q.delete(f);
            end
            for (int r = 0; r < 2; r++)
                if (cv[d][r] && cpl_ready[r]) begin
                    vecs++;
                    if (pend[d][r] == 0 || rsp[d][r*2 +: 2] !== 2'b00) begin
                        errs++;
                        $display("FAIL dut%0d cpl%0d: got resp=%0b with %0d outstanding, expected resp=00 with >0 outstanding", d, r, rsp[d][r*2 +: 2], pend[d][r]);
                    end else pend[d][r]--;
                end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        mid();
        chk_idle("reset");
        step();
        srst = 1'b0;
        // single write from requester 0
        req_valid = 2'b01; req_addr = {3'd0, 3'd3}; req_data = {8'h00, 8'hA5}; req_strb = 2'b01; cpl_ready = 2'b00;
        push2(3'd3, 8'hA5, 1'b1, 0, 1'b1);
        mid();
        chk_rdy("single", 2'b01, 2'b01);
        step();
        req_valid = 2'b00; cpl_ready = 2'b11;
        mid();
        chk("single cpl_valid merge", cv[0], 2'b01);
        chk("single cpl_valid serial", cv[1], 2'b01);
        chk("single cpl_resp merge", rsp[0], 0);
        step();
        mid();
        chk("single cpl dropped", cv[0], 2'b00);
        // fairness: pointer now at 1, grants alternate 1,0,1,0...
        step();
        req_valid = 2'b11; req_addr = {3'd2, 3'd1}; req_data = {8'h20, 8'h10}; req_strb = 2'b11;
        for (int k = 0; k < 8; k++) begin
            int w;
            w = (k % 2 == 0) ? 1 : 0;
            push2(w ? 3'd2 : 3'd1, w ? 8'h20 : 8'h10, 1'b1, w, 1'b1);
            mid();
            chk_rdy($sformatf("fair%0d", k), 2'(1 << w), 2'(1 << w));
            step();
        end
        req_valid = 2'b00;
        mid();
        step();
        // same-address collision with pointer at 1
        req_valid = 2'b11; req_addr = {3'd5, 3'd5}; req_data = {8'h22, 8'h11}; req_strb = 2'b11; cpl_ready = 2'b00;
        push(0, 3'd5, 8'h22, 1'b1, 0, 1'b1);
        pend[0][1]++;
        push(1, 3'd5, 8'h22, 1'b1, 1, 1'b1);
        mid();
        chk_rdy("coll1", 2'b11, 2'b10);
        step();
        push(1, 3'd5, 8'h11, 1'b1, 0, 1'b1);
        mid();
        chk_rdy("coll2", 2'b00, 2'b01);
        chk("coll merged cpl_valid", cv[0], 2'b11);
        chk("coll merged cpl_resp", rsp[0], 0);
        step();
        req_valid = 2'b00; cpl_ready = 2'b11;
        mid();
        chk("coll serial cpl_valid", cv[1], 2'b11);
        step();
        // zero strobe from requester 1 realigns both pointers to 0
        req_valid = 2'b10; req_addr = {3'd7, 3'd0}; req_data = {8'hFF, 8'h00}; req_strb = 2'b00;
        push2(3'd7, 8'h00, 1'b0, 1, 1'b1);
        mid();
        chk_rdy("zero_strb", 2'b10, 2'b10);
        step();
        req_valid = 2'b00;
        mid();
        step();
        // collision with pointer at 0: data from requester 0
        req_valid = 2'b11; req_addr = {3'd2, 3'd2}; req_data = {8'h44, 8'h33}; req_strb = 2'b11; cpl_ready = 2'b00;
        push(0, 3'd2, 8'h33, 1'b1, 0, 1'b1);
        pend[0][1]++;
        push(1, 3'd2, 8'h33, 1'b1, 0, 1'b1);
        mid();
        chk_rdy("coll0_1", 2'b11, 2'b01);
        step();
        push(1, 3'd2, 8'h44, 1'b1, 1, 1'b1);
        mid();
        chk_rdy("coll0_2", 2'b00, 2'b10);
        step();
        req_valid = 2'b00; cpl_ready = 2'b11;
        mid();
        step();
        // completion back-pressure on requester 0
        req_valid = 2'b01; req_addr = {3'd6, 3'd1}; req_data = {8'h66, 8'h55}; req_strb = 2'b11; cpl_ready = 2'b10;
        push2(3'd1, 8'h55, 1'b1, 0, 1'b1);
        mid();
        chk_rdy("bp0", 2'b01, 2'b01);
        step();
        req_valid = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            if (k % 2 == 1) push2(3'd6, 8'h66, 1'b1, 1, 1'b1);
            mid();
            chk_rdy($sformatf("bp%0d", k), (k % 2 == 1) ? 2'b10 : 2'b00, (k % 2 == 1) ? 2'b10 : 2'b00);
            chk($sformatf("bp%0d cpl_valid0", k), cv[0][0], 1'b1);
            step();
        end
        req_valid = 2'b00; cpl_ready = 2'b11;
        mid();
        step();
        // reset while a completion is pending
        req_valid = 2'b01; req_addr = {3'd0, 3'd4}; req_data = {8'h00, 8'h77}; req_strb = 2'b01; cpl_ready = 2'b00;
        push2(3'd4, 8'h77, 1'b1, 0, 1'b0);
        mid();
        chk_rdy("pre_rst", 2'b01, 2'b01);
        step();
        srst = 1'b1; req_valid = 2'b10;
        mid();
        chk_rdy("in_rst", 2'b00, 2'b00);
        chk("in_rst cpl_valid", cv[0], 2'b01);
        step();
        srst = 1'b0; req_valid = 2'b00;
        mid();
        chk_idle("post_rst");
        step();
        // pointer back at 0 after reset: requester 0 wins
        req_valid = 2'b11; req_addr = {3'd3, 3'd2}; req_data = {8'hBB, 8'hAA}; req_strb = 2'b11; cpl_ready = 2'b11;
        push2(3'd2, 8'hAA, 1'b1, 0, 1'b1);
        mid();
        chk_rdy("first_after_rst", 2'b01, 2'b01);
        step();
        req_valid = 2'b00;
        mid();
        step();
        step();
        mid();
        chk("scoreboard drained", q.size(), 0);
        chk("completions drained", pend[0][0] + pend[0][1] + pend[1][0] + pend[1][1], 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
